// File: rtl/branch_resolver.sv
// In-order branch prediction queue; resolves the oldest entry against execute.
// Optional counters enabled by BRANCH_RESOLVER_STATS_EN.
module branch_resolver #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pred_valid,
    input  logic                  pred_taken,
    input  logic [ADDR_WIDTH-1:0] pred_pc,
    input  logic [ADDR_WIDTH-1:0] pred_target,
    output logic                  pred_ready,
    input  logic                  res_valid,
    input  logic                  res_taken,
    input  logic [ADDR_WIDTH-1:0] res_target,
    output logic                  upd_valid,
    output logic                  upd_taken,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  underflow
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic                  taken;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
    } pred_t;

    pred_t         mem [DEPTH];
    pred_t         head;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW:0]   count;
    logic          empty;
    logic          pop;
    logic          mis;
    logic          push;

    assign head       = mem[rptr];
    assign empty      = (count == '0);
    assign pred_ready = (count < FULL) && !mispredict;
    assign pop        = res_valid && !empty;
    assign mis        = pop && ((head.taken != res_taken) ||
                                (head.taken && (head.target != res_target)));
    assign push       = pred_valid && pred_ready && !mis;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {pred_taken, pred_pc, pred_target};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rptr        <= '0;
            wptr        <= '0;
            count       <= '0;
            upd_valid   <= 1'b0;
            upd_taken   <= 1'b0;
            mispredict  <= 1'b0;
            redirect_pc <= '0;
            underflow   <= 1'b0;
        end else begin
            // A mispredict flushes every younger, wrong-path entry.
            if (mis) begin
                rptr  <= '0;
                wptr  <= '0;
                count <= '0;
            end else begin
                if (pop)  rptr <= rptr + PW'(1);
                if (push) wptr <= wptr + PW'(1);
                if (push && !pop)
                    count <= count + (PW+1)'(1);
                else if (pop && !push)
                    count <= count - (PW+1)'(1);
            end
            upd_valid  <= pop;
            upd_taken  <= pop && res_taken;
            mispredict <= mis;
            if (mis)
                redirect_pc <= res_taken ? res_target
                                         : head.pc + ADDR_WIDTH'(4);
            if (res_valid && empty) underflow <= 1'b1;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (pop && (stat_branches != '1))
                stat_branches <= stat_branches + 32'd1;
            if (mis && (stat_mispredicts != '1))
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: queue model plus directed vectors.
// Stats checks compile in when BRANCH_RESOLVER_STATS_EN is defined.
module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int AW    = 32;

    logic          clk;
    logic          rst;
    logic          pred_valid;
    logic          pred_taken;
    logic [AW-1:0] pred_pc;
    logic [AW-1:0] pred_target;
    logic          pred_ready;
    logic          res_valid;
    logic          res_taken;
    logic [AW-1:0] res_target;
    logic          upd_valid;
    logic          upd_taken;
    logic          mispredict;
    logic [AW-1:0] redirect_pc;
    logic          underflow;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0]   stat_branches;
    logic [31:0]   stat_mispredicts;
`endif

    branch_resolver #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .pred_valid(pred_valid),
        .pred_taken(pred_taken),
        .pred_pc(pred_pc),
        .pred_target(pred_target),
        .pred_ready(pred_ready),
        .res_valid(res_valid),
        .res_taken(res_taken),
        .res_target(res_target),
        .upd_valid(upd_valid),
        .upd_taken(upd_taken),
        .mispredict(mispredict),
        .redirect_pc(redirect_pc),
        .underflow(underflow)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          taken;
        logic [31:0] pc;
        logic [31:0] target;
    } ent_t;

    ent_t        mq[$];
    ent_t        mh;
    bit          m_upd_v, m_upd_t, m_mis, m_uf;
    bit          m_pop, m_bad, m_rdy;
    logic [31:0] m_redir;
    int unsigned m_br, m_mc;

    // Reference model: a plain queue updated with the spec rules each edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_upd_v = 0; m_upd_t = 0; m_mis = 0; m_uf = 0;
            m_redir = '0; m_br = 0; m_mc = 0;
        end else begin
            m_rdy = (mq.size() < DEPTH) && !m_mis;
            m_pop = res_valid && (mq.size() > 0);
            m_bad = 0;
            if (m_pop) begin
                mh = mq[0];
                m_bad = (mh.taken != res_taken) ||
                        (mh.taken && mh.target != res_target);
            end
            if (res_valid && mq.size() == 0) m_uf = 1;
            m_upd_v = m_pop;
            m_upd_t = m_pop && res_taken;
            if (m_bad) m_redir = res_taken ? res_target : mh.pc + 32'd4;
            m_mis = m_bad;
            if (m_pop && m_br != 32'hFFFF_FFFF) m_br++;
            if (m_bad && m_mc != 32'hFFFF_FFFF) m_mc++;
            if (m_bad) mq.delete();
            else begin
                if (m_pop) void'(mq.pop_front());
                if (pred_valid && m_rdy)
                    mq.push_back('{pred_taken, pred_pc, pred_target});
            end
        end
    end

    always @(negedge clk) begin
        chk("pred_ready", pred_ready, (mq.size() < DEPTH) && !m_mis);
        chk("upd_valid", upd_valid, m_upd_v);
        chk("upd_taken", upd_taken, m_upd_t);
        chk("mispredict", mispredict, m_mis);
        chk("underflow", underflow, m_uf);
        if (m_mis || !rst) chk("redirect_pc", redirect_pc, m_redir);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_branches", stat_branches, m_br);
        chk("stat_mispredicts", stat_mispredicts, m_mc);
`endif
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_set(input bit t, input logic [31:0] pc,
                            input logic [31:0] tg);
        pred_valid  = 1'b1;
        pred_taken  = t;
        pred_pc     = pc;
        pred_target = tg;
    endtask

    task automatic res_set(input bit t, input logic [31:0] tg);
        res_valid  = 1'b1;
        res_taken  = t;
        res_target = tg;
    endtask

    task automatic clr;
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        pred_valid = 0; pred_taken = 0; pred_pc = '0; pred_target = '0;
        res_valid = 0; res_taken = 0; res_target = '0;
        #12;
        chk("rst upd_valid", upd_valid, 0);
        chk("rst mispredict", mispredict, 0);
        chk("rst redirect", redirect_pc, 0);
        chk("rst underflow", underflow, 0);
        chk("rst pred_ready", pred_ready, 1);
        rst = 1'b1;
        step;

        push_set(0, 32'h100, 32'h0); step; clr;
        res_set(0, 32'h0); step; clr;
        chk("t34 upd_valid", upd_valid, 1);
        chk("t34 upd_taken", upd_taken, 0);
        chk("t34 mispredict", mispredict, 0);
        step;
        chk("t34 upd_pulse", upd_valid, 0);

        push_set(0, 32'h200, 32'h0); step; clr;
        res_set(1, 32'h400); step; clr;
        chk("t35 mispredict", mispredict, 1);
        chk("t35 redirect", redirect_pc, 32'h400);
        chk("t35 ready_low", pred_ready, 0);
        step;
        chk("t35 mis_pulse", mispredict, 0);

        push_set(1, 32'h300, 32'h500); step; clr;
        res_set(1, 32'h504); step; clr;
        chk("t36 mispredict", mispredict, 1);
        chk("t36 redirect", redirect_pc, 32'h504);
        step;

        push_set(1, 32'h600, 32'h700); step; clr;
        res_set(1, 32'h700); step; clr;
        chk("tk_ok mispredict", mispredict, 0);
        chk("tk_ok upd_taken", upd_taken, 1);
        step;

        push_set(1, 32'h800, 32'h900); step; clr;
        res_set(0, 32'h0); step; clr;
        chk("nt redirect", redirect_pc, 32'h804);
        step;

        for (int i = 0; i < 4; i++) begin
            push_set(1, 32'h1000 + i * 16, 32'h1100 + i * 16);
            step;
        end
        clr;
        chk("full ready", pred_ready, 0);
        push_set(1, 32'h2000, 32'h2100);
        res_set(1, 32'h1100);
        step; clr;
        chk("pp ready", pred_ready, 1);
        chk("pp mispredict", mispredict, 0);
        push_set(1, 32'h2004, 32'h2104); step; clr;
        chk("refill ready", pred_ready, 0);
        res_set(1, 32'h1110); step;
        res_set(1, 32'h1120); step;
        res_set(1, 32'h1130); step;
        res_set(1, 32'h2104); step; clr;
        chk("drain order", mispredict, 0);
        step;
        chk("drain ready", pred_ready, 1);

        push_set(0, 32'hA00, 32'h0); step;
        push_set(0, 32'hA04, 32'h0); step;
        push_set(0, 32'hA08, 32'h0); step;
        push_set(0, 32'hA0C, 32'h0);
        res_set(1, 32'h3000);
        step;
        res_valid = 1'b0;
        chk("t38 mispredict", mispredict, 1);
        chk("t38 ready_low", pred_ready, 0);
        step; clr;
        chk("t38 ready_high", pred_ready, 1);

        res_set(0, 32'h0); step; clr;
        chk("uf set", underflow, 1);
        chk("uf no_upd", upd_valid, 0);
        chk("uf no_mis", mispredict, 0);
        step; step;
        chk("uf sticky", underflow, 1);

        push_set(0, 32'h4000, 32'h0); step;
        push_set(0, 32'h4004, 32'h0); step; clr;
        res_set(0, 32'h0); step; clr;
        chk("mr upd_before", upd_valid, 1);
        rst = 1'b0;
        #1;
        chk("mr upd_cleared", upd_valid, 0);
        chk("mr uf_cleared", underflow, 0);
        #2;
        rst = 1'b1;
        step;
        chk("mr ready", pred_ready, 1);
        res_set(0, 32'h0); step; clr;
        chk("mr queue_empty", underflow, 1);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat zero_br", stat_branches, 0);
        chk("stat zero_mc", stat_mispredicts, 0);
`endif
        for (int i = 0; i < 5; i++) begin
            push_set(0, 32'h6000 + i * 8, 32'h0); step; clr;
            res_set((i == 1) || (i == 3), 32'h7000); step; clr;
            step;
        end
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat branches", stat_branches, 5);
        chk("stat mispredicts", stat_mispredicts, 2);
`endif
        step;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 4: number of in-flight prediction entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: PC/target width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 pred_valid  input  1  fetch pushes a prediction for a fetched branch.
REQ-006 pred_taken  input  1  predicted direction.
REQ-007 pred_pc  input  ADDR_WIDTH  PC of predicted branch.
REQ-008 pred_target  input  ADDR_WIDTH  predicted target (meaningful when pred_taken=1).
REQ-009 pred_ready  output  1  queue can accept a push.
REQ-010 res_valid  input  1  execute resolves the oldest in-flight branch.
REQ-011 res_taken  input  1  actual direction.
REQ-012 res_target  input  ADDR_WIDTH  actual target.
REQ-013 upd_valid  output  1  predictor update strobe (drives predictor isBranch).
REQ-014 upd_taken  output  1  actual direction for predictor update (drives isBranchTaken).
REQ-015 mispredict  output  1  one-cycle redirect/flush pulse.
REQ-016 redirect_pc  output  ADDR_WIDTH  correct next PC, valid while mispredict=1.
REQ-017 underflow  output  1  sticky error: resolve with empty queue.

Function
REQ-018 SHALL hold predictions in an in-order FIFO of DEPTH entries {taken, pc, target}.
REQ-019 pred_ready SHALL be combinational: 1 iff count < DEPTH and mispredict=0; full-queue push is not accepted even with simultaneous pop.
REQ-020 Push SHALL occur when pred_valid && pred_ready and no mispredict is detected in the same cycle.
REQ-021 res_valid with non-empty queue SHALL pop the head and compare it with the resolve inputs in that cycle.
REQ-022 Mispredict detected iff head.taken != res_taken, or both taken and head.target != res_target.
REQ-023 Simultaneous accepted push and non-mispredicting pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-024 upd_valid, upd_taken, mispredict, redirect_pc SHALL be registered: asserted the cycle after the resolving cycle, for exactly one cycle.
REQ-025 redirect_pc SHALL be res_target if res_taken, else head.pc + 4 (modulo 2^ADDR_WIDTH).
REQ-026 On detected mispredict, the queue SHALL be emptied at the same edge (younger entries are wrong-path); the same-cycle push is discarded.
REQ-027 Pushes in the cycle mispredict=1 SHALL be refused (pred_ready=0).
REQ-028 res_valid with empty queue SHALL set underflow, produce no upd_valid, no mispredict; underflow stays set until reset.
REQ-029 upd_valid SHALL fire for every valid pop, mispredicted or not.

Reset
REQ-030 While rst=0: queue empty, pointers 0, upd_valid=0, upd_taken=0, mispredict=0, redirect_pc=0, underflow=0, pred_ready=1 after release.
REQ-031 Reset assertion mid-operation SHALL discard all entries and any pending registered outputs immediately.

Configuration
REQ-032 Macro BRANCH_RESOLVER_STATS_EN: when defined, adds outputs stat_branches (32) and stat_mispredicts (32), counting each valid pop and each mispredict, saturating at 0xFFFFFFFF, reset to 0.
REQ-033 Without BRANCH_RESOLVER_STATS_EN those ports and counters SHALL not exist; other behaviour is identical.

Verification
REQ-034 Push {taken=0,pc=0x100}; resolve res_taken=0 -> next cycle upd_valid=1, upd_taken=0, mispredict=0.
REQ-035 Push {taken=0,pc=0x200}; resolve res_taken=1,target=0x400 -> next cycle mispredict=1, redirect_pc=0x400, queue empty.
REQ-036 Push {taken=1,pc=0x300,target=0x500}; resolve taken, target=0x504 -> mispredict=1, redirect_pc=0x504.
REQ-037 Push 4 entries (DEPTH=4) -> pred_ready=0; push+pop same cycle -> push refused, count=3; then push accepted, count=4.
REQ-038 Three entries queued, first mispredicts while pred_valid=1 -> all entries and the push dropped, pred_ready=0 during the mispredict cycle, 1 after.
REQ-039 res_valid with empty queue -> underflow=1 held, upd_valid=0; with stats enabled, 5 pops incl. 2 mispredicts -> stat_branches=5, stat_mispredicts=2.
